ci_fft_bin_avg: RTL and testbench

Downstream stage of the FFT handler. Consumes the 12-bit real-part stream and its new-data strobe, takes the magnitude of each sample, and accumulates per-bin magnitudes over 2^LOG2_FRAMES consecutive FFT frames. It then streams the averaged spectrum, one bin per transfer, over a valid/ready interface to the feature-extraction and host-readout logic.

---
 rtl/ci_fft_bin_avg.sv | 101 ++++++++++
 tb/tb_ci_fft_bin_avg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ci_fft_bin_avg.sv
// Per-bin magnitude averager over 2^LOG2_FRAMES FFT frames; streams the averaged spectrum over valid/ready.
// Optional round-half-up output enabled by defining CI_BINAVG_ROUND_EN (default: truncation).
module ci_fft_bin_avg #(
  parameter int DATLEN      = 12,
  parameter int NPTS        = 64,
  parameter int LOG2_FRAMES = 3,
  localparam int BW         = $clog2(NPTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_nd,
  input  logic [DATLEN-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATLEN-1:0] out_data,
  output logic [BW-1:0]     out_bin,
  output logic              out_last,
  output logic              busy,
  output logic              drop_err
);

  localparam int                     ACCW      = DATLEN + LOG2_FRAMES;
  localparam logic [BW-1:0]          BIN_MAX   = BW'(NPTS - 1);
  localparam logic [LOG2_FRAMES-1:0] FRAME_MAX = '1;

  typedef enum logic {ACCUM, DUMP} state_t;

  state_t                 state, state_next;
  logic [BW-1:0]          wr_bin, rd_bin;
  logic [LOG2_FRAMES-1:0] frame_idx;
  logic [ACCW-1:0]        acc [NPTS];
  logic [DATLEN-1:0]      mag;
  logic [ACCW-1:0]        acc_base;
  logic [ACCW-1:0]        acc_rd;
  logic [DATLEN-1:0]      avg;
  logic                   sample_ok, handshake, last_sample;

  // Two's-complement negate; the most negative input maps to 2^(DATLEN-1) as an unsigned value.
  assign mag         = in_data[DATLEN-1] ? (DATLEN'(0) - in_data) : in_data;
  assign sample_ok   = (state == ACCUM) && in_nd;
  assign handshake   = (state == DUMP) && out_ready;
  assign last_sample = sample_ok && (wr_bin == BIN_MAX) && (frame_idx == FRAME_MAX);
  assign acc_base    = (frame_idx == '0) ? '0 : acc[wr_bin];
  assign acc_rd      = acc[rd_bin];

`ifdef CI_BINAVG_ROUND_EN
  localparam logic [ACCW:0] HALF = (ACCW + 1)'(1) << (LOG2_FRAMES - 1);
  logic [ACCW:0] acc_rnd;
  assign acc_rnd = {1'b0, acc_rd} + HALF;
  assign avg     = DATLEN'(acc_rnd >> LOG2_FRAMES);
`else
  assign avg     = DATLEN'(acc_rd >> LOG2_FRAMES);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (last_sample) state_next = DUMP;
      DUMP:    if (handshake && rd_bin == BIN_MAX) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bin    <= '0;
      frame_idx <= '0;
      rd_bin    <= '0;
      busy      <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      busy <= (state_next == DUMP);
      if (in_nd && state == DUMP) drop_err <= 1'b1;
      // Both counters wrap to zero on the final sample, so DUMP exits straight into frame 0.
      if (sample_ok) begin
        wr_bin <= wr_bin + 1'b1;
        if (wr_bin == BIN_MAX) frame_idx <= frame_idx + 1'b1;
      end
      if (last_sample)    rd_bin <= '0;
      else if (handshake) rd_bin <= rd_bin + 1'b1;
    end
  end

  // NOTE: the accumulator array has no reset; the frame-0 overwrite makes stale contents harmless.
  always_ff @(posedge clk) begin
    if (sample_ok) acc[wr_bin] <= acc_base + ACCW'(mag);
  end

  assign out_valid = (state == DUMP);
  assign out_data  = out_valid ? avg : '0;
  assign out_bin   = out_valid ? rd_bin : '0;
  assign out_last  = out_valid && (rd_bin == BIN_MAX);

endmodule

// File: tb/tb_ci_fft_bin_avg.sv
// Self-checking bench for ci_fft_bin_avg: table-driven frame pairs on a 4-point/2-frame instance,
// plus a 64-point/8-frame instance; expected bins go through scoreboard queues.
`timescale 1ns/1ps
module tb_ci_fft_bin_avg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_nd, a_ready, a_valid, a_last, a_busy, a_drop;
  logic [11:0] a_data, a_out;
  logic [1:0]  a_bin;

  logic        b_nd, b_ready, b_valid, b_last, b_busy, b_drop;
  logic [11:0] b_data, b_out;
  logic [5:0]  b_bin;

  ci_fft_bin_avg #(.DATLEN(12), .NPTS(4), .LOG2_FRAMES(1)) dut_a (
    .clk(clk), .reset(reset), .in_nd(a_nd), .in_data(a_data),
    .out_valid(a_valid), .out_ready(a_ready), .out_data(a_out),
    .out_bin(a_bin), .out_last(a_last), .busy(a_busy), .drop_err(a_drop)
  );

  ci_fft_bin_avg #(.DATLEN(12), .NPTS(64), .LOG2_FRAMES(3)) dut_b (
    .clk(clk), .reset(reset), .in_nd(b_nd), .in_data(b_data),
    .out_valid(b_valid), .out_ready(b_ready), .out_data(b_out),
    .out_bin(b_bin), .out_last(b_last), .busy(b_busy), .drop_err(b_drop)
  );

  typedef struct {
    logic [11:0] data;
    int          bin;
    bit          last;
  } exp_t;

  typedef struct {
    int f1[4];
    int f2[4];
    int trunc[4];
    int rnd[4];
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   b_valid_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Scoreboard monitors: compare the head entry whenever valid, pop on handshake.
  always @(negedge clk) begin
    if (!reset && a_valid) begin
      if (q_a.size() == 0) fail_now("a_unexpected_valid");
      else begin
        check("a_bin",  64'(a_bin),  64'(q_a[0].bin));
        check("a_data", 64'(a_out),  64'(q_a[0].data));
        check("a_last", 64'(a_last), 64'(q_a[0].last));
        check("a_busy", 64'(a_busy), 64'd1);
        if (a_ready) void'(q_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b_valid) begin
      b_valid_cycles++;
      if (q_b.size() == 0) fail_now("b_unexpected_valid");
      else begin
        check("b_bin",  64'(b_bin),  64'(q_b[0].bin));
        check("b_data", 64'(b_out),  64'(q_b[0].data));
        check("b_last", 64'(b_last), 64'(q_b[0].last));
        if (b_ready) void'(q_b.pop_front());
      end
    end
  end

  function automatic int exp_val(input int row, input int k);
`ifdef CI_BINAVG_ROUND_EN
    return vecs[row].rnd[k];
`else
    return vecs[row].trunc[k];
`endif
  endfunction

  task automatic drain_a();
    int n = 0;
    while ((q_a.size() != 0 || a_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("a_drain_timeout");
  endtask

  // mode 0: ready high; mode 1: stall 5 cycles on bin 1; mode 2: inject samples during the dump.
  task automatic run_row(input int row, input int mode);
    exp_t e;
    a_ready = (mode != 1);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        a_nd   = 1'b1;
        a_data = 12'(f == 0 ? vecs[row].f1[k] : vecs[row].f2[k]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      e.data = 12'(exp_val(row, k));
      e.bin  = k;
      e.last = (k == 3);
      q_a.push_back(e);
    end
    @(negedge clk);
    check("a_valid_not_early", 64'(a_valid), 64'd0);
    @(posedge clk); #1;
    a_nd = 1'b0;
    @(negedge clk);
    check("a_valid_latency", 64'(a_valid), 64'd1);
    check("a_busy_latency",  64'(a_busy),  64'd1);
    if (mode == 1) begin
      @(posedge clk); #1; a_ready = 1'b1;
      @(posedge clk); #1; a_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1 a_ready = 1'b1;
    end else if (mode == 2) begin
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (q_a.size() == 0) break;
        a_nd   = 1'b1;
        a_data = 12'd2047;
      end
      a_nd = 1'b0;
    end
    drain_a();
  endtask

  initial begin
    vecs[0].f1 = '{10, -20, 30, -2048};  vecs[0].f2 = '{12, 20, -31, 2048};
    vecs[0].trunc = '{11, 20, 30, 2048}; vecs[0].rnd = '{11, 20, 31, 2048};
    vecs[1].f1 = '{1, 1, 1, 1};          vecs[1].f2 = '{1, 1, 1, 1};
    vecs[1].trunc = '{1, 1, 1, 1};       vecs[1].rnd = '{1, 1, 1, 1};
    vecs[2].f1 = '{4, 4, 4, 4};          vecs[2].f2 = '{4, 4, 4, 4};
    vecs[2].trunc = '{4, 4, 4, 4};       vecs[2].rnd = '{4, 4, 4, 4};
    vecs[3].f1 = '{-1, 0, 2047, -2047};  vecs[3].f2 = '{0, 0, 2047, -2048};
    vecs[3].trunc = '{0, 0, 2047, 2047}; vecs[3].rnd = '{1, 0, 2047, 2048};
    vecs[4].f1 = '{3, -5, 7, -9};        vecs[4].f2 = '{0, 0, 0, 0};
    vecs[4].trunc = '{1, 2, 3, 4};       vecs[4].rnd = '{2, 3, 4, 5};

    reset = 1'b1;
    a_nd = 1'b0; a_data = '0; a_ready = 1'b1;
    b_nd = 1'b0; b_data = '0; b_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", 64'({a_valid, a_last, a_busy, a_drop, a_bin, a_out}), 64'd0);
    end

    run_row(0, 1);
    check("drop_err_clean", 64'(a_drop), 64'd0);
    run_row(4, 2);
    check("drop_err_set", 64'(a_drop), 64'd1);
    run_row(1, 0);
    check("drop_err_sticky", 64'(a_drop), 64'd1);
    run_row(3, 0);
    check("drop_err_sticky2", 64'(a_drop), 64'd1);

    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a_nd   = 1'b1;
      a_data = 12'(1000 + 100 * i);
    end
    @(posedge clk); #1;
    a_nd  = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", 64'({a_valid, a_last, a_busy, a_drop, a_bin, a_out}), 64'd0);
    run_row(2, 0);
    check("drop_err_after_reset", 64'(a_drop), 64'd0);

    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 64; k++) begin
        @(posedge clk); #1;
        b_nd   = 1'b1;
        b_data = 12'(k - 32);
      end
    end
    for (int k = 0; k < 64; k++) begin
      exp_t e;
      e.data = 12'(k < 32 ? 32 - k : k - 32);
      e.bin  = k;
      e.last = (k == 63);
      q_b.push_back(e);
    end
    @(posedge clk); #1;
    b_nd = 1'b0;
    begin
      int n = 0;
      while ((q_b.size() != 0 || b_valid) && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (n >= 300) fail_now("b_drain_timeout");
    end
    check("b_dump_cycles", 64'(b_valid_cycles), 64'd64);
    check("b_drop_err",    64'(b_drop),         64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
